// File: rtl/imm_ext_arbiter.sv
// rtl/imm_ext_arbiter.sv - two-port arbiter sharing one immediate-extension unit (optional macro: IMM_ARB_FIXED_PRIO_EN)
module imm_ext_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [10:0] req0_in,
    input  logic [1:0]  req0_mode,
    input  logic [2:0]  req0_tag,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [10:0] req1_in,
    input  logic [1:0]  req1_mode,
    input  logic [2:0]  req1_tag,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_id,
    output logic [2:0]  out_tag,
    input  logic        out_ready
);

    // Copy the bits below the selected width, replicate the extend bit above it.
    function automatic logic [15:0] extend(input logic [10:0] imm, input logic [1:0] mode);
        logic [15:0] r;
        case (mode)
            2'b00:   r = {11'b0, imm[4:0]};
            2'b01:   r = {{11{imm[4]}}, imm[4:0]};
            2'b10:   r = {{8{imm[7]}}, imm[7:0]};
            default: r = {{5{imm[10]}}, imm[10:0]};
        endcase
        return r;
    endfunction

    logic load_en;
    logic grant0;
    logic grant1;
    logic xfer0;
    logic xfer1;

    assign load_en = ~out_valid | out_ready;

`ifdef IMM_ARB_FIXED_PRIO_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    // Port 0 normally wins; port 1 is forced through once it has waited STARVE_LIMIT grants.
    assign starved = (starve_cnt == CW'(STARVE_LIMIT));
    assign grant1  = req1_valid & (~req0_valid | starved);

    // Count port-0 wins while port 1 waits; clear when port 1 is served or idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!req1_valid || xfer1) begin
            starve_cnt <= '0;
        end else if (xfer0 && !starved) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end
`else
    logic last_grant;

    // On a tie the port that was not served last wins.
    assign grant1 = req1_valid & (~req0_valid | ~last_grant);

    // Remember the most recent transfer; blocked grants do not count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (xfer0) begin
            last_grant <= 1'b0;
        end else if (xfer1) begin
            last_grant <= 1'b1;
        end
    end
`endif

    assign grant0     = req0_valid & ~grant1;
    assign req0_ready = grant0 & load_en & rst_n;
    assign req1_ready = grant1 & load_en & rst_n;
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;

    // Result register: load on transfer, empty on drain without refill, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            out_id    <= 1'b0;
            out_tag   <= 3'd0;
        end else if (xfer0) begin
            out_valid <= 1'b1;
            out_data  <= extend(req0_in, req0_mode);
            out_id    <= 1'b0;
            out_tag   <= req0_tag;
        end else if (xfer1) begin
            out_valid <= 1'b1;
            out_data  <= extend(req1_in, req1_mode);
            out_id    <= 1'b1;
            out_tag   <= req1_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
